// File: rtl/issue_request_array.sv
// Issue-queue readiness tracker: per-entry valid and source-ready state, wakeup snooping,
// request generation for the select encoder, grant-driven deallocation and free-entry count.
// Optional macro ISSUE_REQ_REG_EN registers request_vector_o, which adds one cycle of select latency.
module issue_request_array #(
  parameter int IQ_DEPTH      = 32,
  parameter int IQ_INDEX_BITS = $clog2(IQ_DEPTH),
  parameter int PHY_REG_BITS  = 7,
  parameter int WAKEUP_PORTS  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush_i,
  input  logic                                 dispatch_valid_i,
  input  logic [IQ_INDEX_BITS-1:0]             dispatch_index_i,
  input  logic [PHY_REG_BITS-1:0]              dispatch_src1_tag_i,
  input  logic                                 dispatch_src1_ready_i,
  input  logic [PHY_REG_BITS-1:0]              dispatch_src2_tag_i,
  input  logic                                 dispatch_src2_ready_i,
  input  logic [WAKEUP_PORTS-1:0]              wakeup_valid_i,
  input  logic [WAKEUP_PORTS*PHY_REG_BITS-1:0] wakeup_tag_i,
  input  logic [IQ_DEPTH-1:0]                  grant_vector_i,
  input  logic                                 issue_stall_i,
  output logic [IQ_DEPTH-1:0]                  request_vector_o,
  output logic [IQ_DEPTH-1:0]                  occupied_vector_o,
  output logic [IQ_INDEX_BITS:0]               free_count_o,
  output logic                                 error_o
);

  localparam logic [IQ_INDEX_BITS:0] FULL_COUNT = (IQ_INDEX_BITS+1)'(IQ_DEPTH);
  localparam logic [IQ_DEPTH-1:0]    ONE_VEC    = {{(IQ_DEPTH-1){1'b0}}, 1'b1};

  logic [IQ_DEPTH-1:0]     valid_q, src1_rdy_q, src2_rdy_q;
  logic [PHY_REG_BITS-1:0] src1_tag_q [IQ_DEPTH];
  logic [PHY_REG_BITS-1:0] src2_tag_q [IQ_DEPTH];
  logic [IQ_INDEX_BITS:0]  free_count_q;
  logic                    error_q;

  logic [IQ_DEPTH-1:0]     req_comb, req_visible, dealloc;
  logic [IQ_DEPTH-1:0]     wake1, wake2;
  logic [IQ_DEPTH-1:0]     valid_d, src1_rdy_d, src2_rdy_d;
  logic [IQ_INDEX_BITS:0]  dealloc_count, free_count_d;
  logic                    multi_grant, disp_conflict, disp_accept;
  logic                    disp_src1_rdy, disp_src2_rdy, error_d;

  function automatic logic tag_match(input logic [PHY_REG_BITS-1:0] tag,
                                     input logic [WAKEUP_PORTS-1:0] wv,
                                     input logic [WAKEUP_PORTS*PHY_REG_BITS-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      if (wv[p] && (wt[p*PHY_REG_BITS +: PHY_REG_BITS] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [IQ_INDEX_BITS:0] pop_count(input logic [IQ_DEPTH-1:0] v);
    logic [IQ_INDEX_BITS:0] cnt;
    cnt = '0;
    for (int i = 0; i < IQ_DEPTH; i++) cnt = cnt + (IQ_INDEX_BITS+1)'(v[i]);
    return cnt;
  endfunction

  assign req_comb = valid_q & src1_rdy_q & src2_rdy_q;

`ifdef ISSUE_REQ_REG_EN
  logic [IQ_DEPTH-1:0] req_q;

  // The encoder works from last cycle's request; entries that left since then are masked off.
  always_ff @(posedge clk) begin
    if (reset || flush_i) req_q <= '0;
    else                  req_q <= req_comb;
  end

  assign req_visible = req_q & valid_q;
`else
  assign req_visible = req_comb;
`endif

  assign request_vector_o  = req_visible;
  assign occupied_vector_o = valid_q;
  assign free_count_o      = free_count_q;
  assign error_o           = error_q;

  // Grants only retire entries the encoder could legitimately have picked.
  always_comb begin
    dealloc     = issue_stall_i ? '0 : (grant_vector_i & req_visible);
    multi_grant = !issue_stall_i && ((grant_vector_i & (grant_vector_i - ONE_VEC)) != '0);
    dealloc_count = pop_count(dealloc);
    for (int k = 0; k < IQ_DEPTH; k++) begin
      wake1[k] = tag_match(src1_tag_q[k], wakeup_valid_i, wakeup_tag_i);
      wake2[k] = tag_match(src2_tag_q[k], wakeup_valid_i, wakeup_tag_i);
    end
    disp_src1_rdy = dispatch_src1_ready_i
                  | tag_match(dispatch_src1_tag_i, wakeup_valid_i, wakeup_tag_i);
    disp_src2_rdy = dispatch_src2_ready_i
                  | tag_match(dispatch_src2_tag_i, wakeup_valid_i, wakeup_tag_i);
    disp_conflict = dispatch_valid_i && valid_q[dispatch_index_i] && !dealloc[dispatch_index_i];
    disp_accept   = dispatch_valid_i && !disp_conflict;
  end

  // A dispatch overrides both deallocation and wakeup on its own entry.
  always_comb begin
    valid_d    = valid_q & ~dealloc;
    src1_rdy_d = src1_rdy_q | (valid_q & wake1);
    src2_rdy_d = src2_rdy_q | (valid_q & wake2);
    if (disp_accept) begin
      valid_d[dispatch_index_i]    = 1'b1;
      src1_rdy_d[dispatch_index_i] = disp_src1_rdy;
      src2_rdy_d[dispatch_index_i] = disp_src2_rdy;
    end
    free_count_d = free_count_q + dealloc_count
                 - {{IQ_INDEX_BITS{1'b0}}, disp_accept};
    error_d      = error_q | disp_conflict | multi_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      src1_rdy_q   <= '0;
      src2_rdy_q   <= '0;
      free_count_q <= FULL_COUNT;
      error_q      <= 1'b0;
    end else if (flush_i) begin
      valid_q      <= '0;
      free_count_q <= FULL_COUNT;
    end else begin
      valid_q      <= valid_d;
      src1_rdy_q   <= src1_rdy_d;
      src2_rdy_q   <= src2_rdy_d;
      free_count_q <= free_count_d;
      error_q      <= error_d;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && disp_accept) begin
      src1_tag_q[dispatch_index_i] <= dispatch_src1_tag_i;
      src2_tag_q[dispatch_index_i] <= dispatch_src2_tag_i;
    end
  end

endmodule

// File: tb/tb_issue_request_array.sv
// Self-checking bench for issue_request_array: an entry-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_issue_request_array;

  localparam int D  = 32;
  localparam int IB = 5;
  localparam int TB = 7;
  localparam int WP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i;
  logic          dispatch_valid_i;
  logic [IB-1:0] dispatch_index_i;
  logic [TB-1:0] dispatch_src1_tag_i, dispatch_src2_tag_i;
  logic          dispatch_src1_ready_i, dispatch_src2_ready_i;
  logic [WP-1:0] wakeup_valid_i;
  logic [WP*TB-1:0] wakeup_tag_i;
  logic [D-1:0]  grant_vector_i;
  logic          issue_stall_i;
  logic [D-1:0]  request_vector_o, occupied_vector_o;
  logic [IB:0]   free_count_o;
  logic          error_o;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  // Reference model: one record per entry, counts derived from the valid set.
  bit [D-1:0]  m_valid, m_r1, m_r2;
  bit [TB-1:0] m_t1 [D];
  bit [TB-1:0] m_t2 [D];
  bit          m_err;

  issue_request_array dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_index_i(dispatch_index_i),
    .dispatch_src1_tag_i(dispatch_src1_tag_i), .dispatch_src1_ready_i(dispatch_src1_ready_i),
    .dispatch_src2_tag_i(dispatch_src2_tag_i), .dispatch_src2_ready_i(dispatch_src2_ready_i),
    .wakeup_valid_i(wakeup_valid_i), .wakeup_tag_i(wakeup_tag_i),
    .grant_vector_i(grant_vector_i), .issue_stall_i(issue_stall_i),
    .request_vector_o(request_vector_o), .occupied_vector_o(occupied_vector_o),
    .free_count_o(free_count_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  function automatic bit broadcast_hit(input bit [TB-1:0] tag);
    for (int p = 0; p < WP; p++)
      if (wakeup_valid_i[p] && wakeup_tag_i[p*TB +: TB] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [D-1:0] model_request();
    return m_valid & m_r1 & m_r2;
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int k = 0; k < D; k++) if (!m_valid[k]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = '0; m_r1 = '0; m_r2 = '0; m_err = 1'b0;
    end else if (flush_i) begin
      m_valid = '0;
    end else begin
      bit [D-1:0] req_now, still_valid;
      req_now     = model_request();
      still_valid = m_valid;
      if (!issue_stall_i) begin
        for (int k = 0; k < D; k++) if (grant_vector_i[k] && req_now[k]) still_valid[k] = 1'b0;
        if ($countones(grant_vector_i) > 1) m_err = 1'b1;
      end
      for (int k = 0; k < D; k++) if (m_valid[k]) begin
        if (broadcast_hit(m_t1[k])) m_r1[k] = 1'b1;
        if (broadcast_hit(m_t2[k])) m_r2[k] = 1'b1;
      end
      if (dispatch_valid_i) begin
        if (still_valid[dispatch_index_i]) m_err = 1'b1;
        else begin
          still_valid[dispatch_index_i] = 1'b1;
          m_t1[dispatch_index_i] = dispatch_src1_tag_i;
          m_t2[dispatch_index_i] = dispatch_src2_tag_i;
          m_r1[dispatch_index_i] = dispatch_src1_ready_i | broadcast_hit(dispatch_src1_tag_i);
          m_r2[dispatch_index_i] = dispatch_src2_ready_i | broadcast_hit(dispatch_src2_tag_i);
        end
      end
      m_valid = still_valid;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model request", 64'(request_vector_o), 64'(model_request()));
      checkOutput("model occupied", 64'(occupied_vector_o), 64'(m_valid));
      checkOutput("model free", 64'(free_count_o), 64'(model_free()));
      checkOutput("model error", 64'(error_o), 64'(m_err));
    end
  end

  task automatic clearInputs();
    reset = 1'b0; flush_i = 1'b0; dispatch_valid_i = 1'b0; dispatch_index_i = '0;
    dispatch_src1_tag_i = '0; dispatch_src1_ready_i = 1'b0;
    dispatch_src2_tag_i = '0; dispatch_src2_ready_i = 1'b0;
    wakeup_valid_i = '0; wakeup_tag_i = '0; grant_vector_i = '0; issue_stall_i = 1'b0;
  endtask

  // Inputs set before the call are sampled at the next rising edge; returns mid-cycle.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
    #1;
    clearInputs();
  endtask

  task automatic setDispatch(input int idx, input bit [TB-1:0] t1, input bit r1,
                             input bit [TB-1:0] t2, input bit r2);
    dispatch_valid_i = 1'b1; dispatch_index_i = IB'(idx);
    dispatch_src1_tag_i = t1; dispatch_src1_ready_i = r1;
    dispatch_src2_tag_i = t2; dispatch_src2_ready_i = r2;
  endtask

  task automatic setWakeup(input int port, input bit [TB-1:0] tag);
    wakeup_valid_i[port] = 1'b1;
    wakeup_tag_i[port*TB +: TB] = tag;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus();
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    applyStimulus();
    started = 1;
    doReset();
    checkOutput("reset request", 64'(request_vector_o), 64'h0);
    checkOutput("reset occupied", 64'(occupied_vector_o), 64'h0);
    checkOutput("reset free", 64'(free_count_o), 64'd32);
    checkOutput("reset error", 64'(error_o), 64'h0);

    setDispatch(3, 7'h01, 1, 7'h02, 1); applyStimulus();
    checkOutput("disp3 request", 64'(request_vector_o), 64'h8);
    checkOutput("disp3 free", 64'(free_count_o), 64'd31);

    setDispatch(5, 7'h12, 0, 7'h03, 1); applyStimulus();
    checkOutput("disp5 request", 64'(request_vector_o), 64'h8);
    checkOutput("disp5 occupied", 64'(occupied_vector_o), 64'h28);
    setWakeup(1, 7'h12); applyStimulus();
    checkOutput("wake5 request", 64'(request_vector_o), 64'h28);

    setDispatch(7, 7'h04, 1, 7'h20, 0); setWakeup(0, 7'h20); applyStimulus();
    checkOutput("bypass7 request", 64'(request_vector_o), 64'hA8);
    checkOutput("bypass7 free", 64'(free_count_o), 64'd29);

    grant_vector_i = 32'h8; applyStimulus();
    checkOutput("grant3 request", 64'(request_vector_o), 64'hA0);
    grant_vector_i = 32'h1; applyStimulus();
    checkOutput("grant idle entry", 64'(request_vector_o), 64'hA0);
    checkOutput("grant idle error", 64'(error_o), 64'h0);
    grant_vector_i = 32'h20; applyStimulus();
    grant_vector_i = 32'h80; applyStimulus();
    checkOutput("drained free", 64'(free_count_o), 64'd32);

    setDispatch(2, 7'h05, 1, 7'h06, 1); applyStimulus();
    setDispatch(4, 7'h07, 1, 7'h08, 1); applyStimulus();
    grant_vector_i = 32'h4; issue_stall_i = 1'b1; applyStimulus();
    checkOutput("stall request", 64'(request_vector_o), 64'h14);
    checkOutput("stall free", 64'(free_count_o), 64'd30);
    grant_vector_i = 32'h4; applyStimulus();
    checkOutput("grant2 request", 64'(request_vector_o), 64'h10);
    checkOutput("grant2 free", 64'(free_count_o), 64'd31);

    setDispatch(2, 7'h05, 1, 7'h06, 1); applyStimulus();
    grant_vector_i = 32'h4; setDispatch(2, 7'h40, 0, 7'h09, 1); applyStimulus();
    checkOutput("regrant occupied", 64'(occupied_vector_o), 64'h14);
    checkOutput("regrant request", 64'(request_vector_o), 64'h10);
    checkOutput("regrant error", 64'(error_o), 64'h0);
    setWakeup(0, 7'h40); applyStimulus();
    checkOutput("regrant wake", 64'(request_vector_o), 64'h14);

    grant_vector_i = 32'h14; applyStimulus();
    checkOutput("multigrant request", 64'(request_vector_o), 64'h0);
    checkOutput("multigrant free", 64'(free_count_o), 64'd32);
    checkOutput("multigrant error", 64'(error_o), 64'h1);

    doReset();
    checkOutput("rereset error", 64'(error_o), 64'h0);
    setDispatch(2, 7'h05, 1, 7'h06, 1); applyStimulus();
    setDispatch(4, 7'h07, 1, 7'h08, 1); applyStimulus();
    setDispatch(4, 7'h33, 0, 7'h34, 0); applyStimulus();
    checkOutput("conflict request", 64'(request_vector_o), 64'h14);
    checkOutput("conflict error", 64'(error_o), 64'h1);
    checkOutput("conflict free", 64'(free_count_o), 64'd30);
    for (int i = 10; i < 18; i++) begin
      setDispatch(i, TB'(i), i[0], TB'(i + 40), 1'b1); applyStimulus();
    end
    checkOutput("ten valid free", 64'(free_count_o), 64'd22);
    flush_i = 1'b1; setDispatch(20, 7'h01, 1, 7'h01, 1); applyStimulus();
    checkOutput("flush free", 64'(free_count_o), 64'd32);
    checkOutput("flush occupied", 64'(occupied_vector_o), 64'h0);
    checkOutput("flush error", 64'(error_o), 64'h1);

    doReset();
    for (int i = 0; i < D; i++) begin
      setDispatch(i, TB'(i), 1'b1, TB'(i), 1'b1); applyStimulus();
    end
    checkOutput("full free", 64'(free_count_o), 64'd0);
    checkOutput("full error", 64'(error_o), 64'h0);
    setDispatch(0, 7'h11, 0, 7'h11, 0); applyStimulus();
    checkOutput("overfill free", 64'(free_count_o), 64'd0);
    checkOutput("overfill error", 64'(error_o), 64'h1);
    checkOutput("overfill request", 64'(request_vector_o), 64'hFFFFFFFF);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_request_array.md
Name: issue_request_array

Overview:
- Per-entry readiness tracker for the issue queue. It sits directly upstream of the select priority encoder.
- Holds a valid bit and two source-operand ready bits per IQ entry.
- Snoops wakeup tag broadcasts and drives the request vector into the encoder.
- Consumes the one-hot grant coming back from the encoder to deallocate the issued entry and maintain a free-entry count.

Parameters:
- IQ_DEPTH, 32, number of issue-queue entries (power of 2, >=4).
- IQ_INDEX_BITS, $clog2(IQ_DEPTH), entry index width.
- PHY_REG_BITS, 7, physical register tag width.
- WAKEUP_PORTS, 2, number of tag broadcast buses per cycle.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; invalidates all entries.
- dispatch_valid_i  in  1  write one entry this cycle.
- dispatch_index_i  in  IQ_INDEX_BITS  entry to write.
- dispatch_src1_tag_i  in  PHY_REG_BITS  source 1 physical tag.
- dispatch_src1_ready_i  in  1  source 1 already ready at dispatch.
- dispatch_src2_tag_i  in  PHY_REG_BITS  source 2 physical tag.
- dispatch_src2_ready_i  in  1  source 2 already ready at dispatch.
- wakeup_valid_i  in  WAKEUP_PORTS  per-port broadcast valid.
- wakeup_tag_i  in  WAKEUP_PORTS*PHY_REG_BITS  broadcast tags; port p occupies bits [p*PHY_REG_BITS +: PHY_REG_BITS].
- grant_vector_i  in  IQ_DEPTH  one-hot grant from the priority encoder.
- issue_stall_i  in  1  downstream cannot accept; grant must not deallocate.
- request_vector_o  out  IQ_DEPTH  per entry: valid & src1_rdy & src2_rdy.
- occupied_vector_o  out  IQ_DEPTH  per-entry valid bits.
- free_count_o  out  IQ_INDEX_BITS+1  number of invalid entries.
- error_o  out  1  sticky protocol-violation flag.

Behaviour:
- State per entry: valid, src1_tag, src1_rdy, src2_tag, src2_rdy. All state updates occur on the rising clk edge.
- Reset: all valid=0, all rdy=0, free_count_o=IQ_DEPTH, error_o=0, request_vector_o=0, occupied_vector_o=0.
- Flush: takes priority over dispatch, grant and wakeup. Next cycle all valid=0 and free_count_o=IQ_DEPTH. error_o is unchanged.
- request_vector_o is combinational from registered state only, with no input-to-output path. The encoder therefore sees it in the same cycle.
- Wakeup: for each valid entry and each source, a match against any valid wakeup port sets that rdy bit at the next edge. rdy bits never clear while the entry is valid.
- Dispatch: writes tags, sets valid=1, rdy = dispatch_srcN_ready_i OR a same-cycle wakeup match. This bypass means no wakeup is lost in the dispatch cycle.
- Dispatch to an entry already valid (and not being deallocated this cycle): the write is dropped and error_o is set.
- Grant, with issue_stall_i=0: each entry with grant bit=1 and request bit=1 clears valid at the next edge.
  - A grant bit on a non-requesting entry is ignored.
  - More than one grant bit set: all requesting entries are cleared and error_o is set.
- Grant with issue_stall_i=1: no deallocation; the entry keeps requesting.
- Same-cycle grant-dealloc of entry k plus dispatch to k: legal. The dispatch wins and k holds the new contents.
- free_count update: next = count + deallocs - accepted dispatches.
  - Never exceeds IQ_DEPTH and never underflows.
  - A dispatch when the count is 0 is necessarily to a valid entry, so it is dropped with error_o set.
- error_o stays set until reset.

Optional Feature:
- Macro: ISSUE_REQ_REG_EN.
- Defined:
  - request_vector_o is registered: its value is the combinational request vector from the previous cycle, masked by current valid.
  - Select latency grows by one cycle.
  - Grants on entries that are no longer valid are ignored.
  - Reset and flush drive the register to 0.
- Undefined: request_vector_o is combinational as specified above.

Test Plan:
- Reset, then dispatch idx 3 with both sources ready -> next cycle request_vector_o=0x00000008, free_count_o=31.
- Dispatch idx 5 with src1 tag 0x12 not ready; later wakeup port1 tag 0x12 -> request bit 5 rises one cycle after the wakeup.
- Dispatch idx 7 with src2 tag 0x20 not ready while the same cycle broadcasts tag 0x20 on port0 -> request bit 7 is set the next cycle (bypass).
- Entries 2 and 4 requesting, grant 0x4 with issue_stall_i=1 -> both entries are still requesting; repeat with stall=0 -> bit 2 clears and free_count_o increments.
- Dispatch to occupied idx 4 -> contents unchanged and error_o=1; a flush with 10 entries valid -> free_count_o=32 and occupied_vector_o=0 next cycle, error_o still 1.
- Grant 0x14 with entries 2 and 4 requesting -> both clear and error_o=1.
